fft_xfer_sched: RTL and testbench
=================================

Name: fft_xfer_sched

Overview:
- Sequences one FFT signal transfer between the memory arbiter and the fft accelerator.
- On a start pulse it reads BLKS_PER_SIG 512-bit blocks of the signal from host memory and feeds them into the accelerator input FIFO.
- It then waits for the calculation to finish, drains the same number of result blocks back to memory, and pulses done.
- Sits between the CPU start decode, the fft accelerator and the memory arbiter in proc.

Parameters:
BLK_W, 512, data block width in bits (one cache line / DMA beat)
BLKS_PER_SIG, 128, blocks per signal (8 KB at 512 b)
ADDR_W, 32, memory address width
SIG_BASE, 32'h1000_0000, byte base address of signal 0

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; begin transfer of sig_num
sig_num  in  18  signal number to transfer
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle pulse when all result blocks are written
mem_rd_req  out  1  block read request to arbiter, level
mem_wr_req  out  1  block write request to arbiter, level
mem_addr  out  ADDR_W  byte address of current block
mem_wr_data  out  BLK_W  write block data
mem_rd_data  in  BLK_W  read block data, valid with mem_ack
mem_ack  in  1  read data valid / write complete for the current request
acc_in_valid  out  1  block presented to accelerator input
acc_in_data  out  BLK_W  input block
acc_in_ready  in  1  accelerator accepts input block
acc_out_valid  in  1  accelerator result block available
acc_out_data  in  BLK_W  result block
acc_out_ready  out  1  scheduler accepts result block
acc_calc_done  in  1  one-cycle pulse: accelerator finished computing

Behaviour:
- Single clock domain; all outputs registered.
- Reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - busy, done, mem_rd_req, mem_wr_req, acc_in_valid, acc_out_ready = 0.
  - mem_addr, mem_wr_data, acc_in_data = 0.
  - block counter = 0; calc_done flag = 0.
- Addressing: mem_addr = SIG_BASE + (sig_num_latched << 13) + (blk << 6), computed modulo 2^ADDR_W (wrap, no error). blk counter is $clog2(BLKS_PER_SIG) bits.
- IDLE:
  - start=1: latch sig_num, blk=0, busy=1, go RD_REQ.
  - mem_ack, acc_* inputs and acc_calc_done are ignored.
- RD_REQ:
  - mem_rd_req=1, mem_addr held stable until mem_ack.
  - On mem_ack: capture mem_rd_data into acc_in_data, drop mem_rd_req, go RD_PUSH.
- RD_PUSH:
  - acc_in_valid=1, data held until acc_in_ready.
  - On acceptance: if blk==BLKS_PER_SIG-1 then blk=0 and go CALC; else blk+1 and go RD_REQ.
- CALC:
  - Wait for calc_done flag.
  - The flag is set by any acc_calc_done pulse from the cycle after start acceptance onward, so an early pulse is not lost.
  - Flag set: clear it, go WR_WAIT.
- WR_WAIT:
  - acc_out_ready=1.
  - On acc_out_valid: capture acc_out_data into mem_wr_data, drop acc_out_ready, go WR_REQ.
- WR_REQ:
  - mem_wr_req=1 with stable mem_addr and mem_wr_data until mem_ack.
  - On mem_ack: if last block go DONE; else blk+1 and go WR_WAIT.
- DONE: done=1 for exactly one cycle, busy=1; next cycle busy=0, state IDLE.
- Invariants:
  - mem_rd_req and mem_wr_req are never both high.
  - Requests are never dropped before mem_ack.
  - At most one block is buffered at a time.
- Minimum latency: 2 cycles per read block and 2 per write block, assuming ack/ready/valid in the same cycle the request is asserted.
- Minimum start-to-done: 4*BLKS_PER_SIG+2 cycles, with calc_done already latched.
- A start while busy is ignored; sig_num is not re-latched.
- A mem_ack outside RD_REQ/WR_REQ is ignored.
- Reset mid-operation aborts immediately: all request/valid lines drop in the reset cycle and no done pulse is generated.

Test Plan:
- Immediate ack/ready/valid, sig_num=3, BLKS_PER_SIG=128, calc_done pulsed in CALC:
  - First read addr 0x1000_6000, last read 0x1000_7FC0.
  - 128 input pushes in order, then 128 writes to the same addresses.
  - done pulses once; busy falls the next cycle.
- Random backpressure (acc_in_ready 30%, mem_ack delay 0-7 cycles):
  - mem_addr and data stay stable while waiting.
  - Block order and data are preserved end to end.
  - The two request lines never overlap.
- acc_calc_done pulsed during block 5 read: the flag latches, CALC exits one cycle after entry, no hang.
- start pulsed with sig_num=9 during the write phase of a sig_num=2 run: ignored; all addresses stay in the 0x1000_4000 range; exactly one done.
- Reset asserted while in RD_PUSH at blk=40: next cycle all outputs at reset values, no done pulse; a following start at sig_num=0 reads from 0x1000_0000.
- sig_num=18'h3FFFF: first addr = (0x1000_0000 + 0x7FFF_E000) mod 2^32 = 0x8FFF_E000; the run completes normally.

Source files
------------

// File: rtl/fft_xfer_sched_if.sv
// fft_xfer_sched_if
// Groups the start/status, memory-arbiter and accelerator handshake signals
// of the FFT transfer scheduler into one bundle.
//   master : the scheduler side (drives requests, accelerator input, status)
//   slave  : the environment side (CPU start decode, arbiter, accelerator)
// Signals:
//   start/sig_num          transfer request from the CPU start decode
//   busy/done              transfer status back to the CPU
//   mem_*                  block read/write requests to the memory arbiter
//   acc_in_*               block stream into the accelerator input FIFO
//   acc_out_*              result block stream from the accelerator
//   acc_calc_done          accelerator finished computing
interface fft_xfer_sched_if #(
    parameter int BLK_W  = 512,
    parameter int ADDR_W = 32
);
    localparam int SIG_W = 18;

    logic              start;
    logic [SIG_W-1:0]  sig_num;
    logic              busy;
    logic              done;

    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wr_data;
    logic [BLK_W-1:0]  mem_rd_data;
    logic              mem_ack;

    logic              acc_in_valid;
    logic [BLK_W-1:0]  acc_in_data;
    logic              acc_in_ready;
    logic              acc_out_valid;
    logic [BLK_W-1:0]  acc_out_data;
    logic              acc_out_ready;
    logic              acc_calc_done;

    modport master (
        input  start, sig_num, mem_rd_data, mem_ack,
               acc_in_ready, acc_out_valid, acc_out_data, acc_calc_done,
        output busy, done, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
               acc_in_valid, acc_in_data, acc_out_ready
    );

    modport slave (
        output start, sig_num, mem_rd_data, mem_ack,
               acc_in_ready, acc_out_valid, acc_out_data, acc_calc_done,
        input  busy, done, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
               acc_in_valid, acc_in_data, acc_out_ready
    );
endinterface

// File: rtl/fft_xfer_sched.sv
// fft_xfer_sched
// Sequences one FFT signal transfer: on start it reads BLKS_PER_SIG blocks of
// the selected signal from memory into the accelerator, waits for the
// accelerator to finish, writes the same number of result blocks back to the
// same addresses and pulses done. At most one block is buffered at a time.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  fft_xfer_sched_if.master (start/status, memory arbiter, accelerator)
// All outputs are registered.
module fft_xfer_sched #(
    parameter int                BLK_W        = 512,
    parameter int                BLKS_PER_SIG = 128,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] SIG_BASE     = 32'h1000_0000
) (
    input  logic             clk,
    input  logic             rst,
    fft_xfer_sched_if.master bus
);
    localparam int SIG_W     = 18;
    localparam int BLK_CNT_W = (BLKS_PER_SIG > 1) ? $clog2(BLKS_PER_SIG) : 1;
    localparam logic [BLK_CNT_W-1:0] LAST_BLK = BLK_CNT_W'(BLKS_PER_SIG - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_PUSH,
        CALC,
        WR_WAIT,
        WR_REQ,
        DONE
    } stateT;

    stateT              state, stateNext;
    logic [BLK_CNT_W-1:0] blk, blkNext;
    logic [SIG_W-1:0]   sigLatched, sigNext;
    logic               calcFlag, calcFlagNext;

    logic               busyReg, busyNext;
    logic               doneReg, doneNext;
    logic               rdReqReg, rdReqNext;
    logic               wrReqReg, wrReqNext;
    logic [ADDR_W-1:0]  addrReg, addrNext;
    logic [BLK_W-1:0]   wrDataReg, wrDataNext;
    logic               inValidReg, inValidNext;
    logic [BLK_W-1:0]   inDataReg, inDataNext;
    logic               outReadyReg, outReadyNext;

    logic               lastBlk;
    logic [BLK_CNT_W-1:0] blkInc;

    // Each signal occupies 8 KB and each block 64 bytes; the sum wraps
    // modulo 2^ADDR_W by construction of the fixed-width arithmetic.
    function automatic logic [ADDR_W-1:0] blockAddr(
        input logic [SIG_W-1:0]     sig,
        input logic [BLK_CNT_W-1:0] b
    );
        return SIG_BASE + (ADDR_W'(sig) << 13) + (ADDR_W'(b) << 6);
    endfunction

    assign lastBlk = (blk == LAST_BLK);
    assign blkInc  = blk + BLK_CNT_W'(1);

    assign bus.busy          = busyReg;
    assign bus.done          = doneReg;
    assign bus.mem_rd_req    = rdReqReg;
    assign bus.mem_wr_req    = wrReqReg;
    assign bus.mem_addr      = addrReg;
    assign bus.mem_wr_data   = wrDataReg;
    assign bus.acc_in_valid  = inValidReg;
    assign bus.acc_in_data   = inDataReg;
    assign bus.acc_out_ready = outReadyReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            blk         <= '0;
            sigLatched  <= '0;
            calcFlag    <= 1'b0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
            rdReqReg    <= 1'b0;
            wrReqReg    <= 1'b0;
            addrReg     <= '0;
            wrDataReg   <= '0;
            inValidReg  <= 1'b0;
            inDataReg   <= '0;
            outReadyReg <= 1'b0;
        end else begin
            state       <= stateNext;
            blk         <= blkNext;
            sigLatched  <= sigNext;
            calcFlag    <= calcFlagNext;
            busyReg     <= busyNext;
            doneReg     <= doneNext;
            rdReqReg    <= rdReqNext;
            wrReqReg    <= wrReqNext;
            addrReg     <= addrNext;
            wrDataReg   <= wrDataNext;
            inValidReg  <= inValidNext;
            inDataReg   <= inDataNext;
            outReadyReg <= outReadyNext;
        end
    end

    always_comb begin
        stateNext    = state;
        blkNext      = blk;
        sigNext      = sigLatched;
        calcFlagNext = calcFlag;
        busyNext     = busyReg;
        doneNext     = 1'b0;
        rdReqNext    = rdReqReg;
        wrReqNext    = wrReqReg;
        addrNext     = addrReg;
        wrDataNext   = wrDataReg;
        inValidNext  = inValidReg;
        inDataNext   = inDataReg;
        outReadyNext = outReadyReg;

        // The accelerator may finish while reads are still in flight, so the
        // pulse is remembered from the cycle after start acceptance onward.
        if (state == IDLE) begin
            calcFlagNext = 1'b0;
        end else if (bus.acc_calc_done) begin
            calcFlagNext = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    sigNext   = bus.sig_num;
                    blkNext   = '0;
                    busyNext  = 1'b1;
                    rdReqNext = 1'b1;
                    addrNext  = blockAddr(bus.sig_num, '0);
                    stateNext = RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus.mem_ack) begin
                    inDataNext  = bus.mem_rd_data;
                    rdReqNext   = 1'b0;
                    inValidNext = 1'b1;
                    stateNext   = RD_PUSH;
                end
            end
            RD_PUSH: begin
                if (bus.acc_in_ready) begin
                    inValidNext = 1'b0;
                    if (lastBlk) begin
                        blkNext   = '0;
                        stateNext = CALC;
                    end else begin
                        blkNext   = blkInc;
                        rdReqNext = 1'b1;
                        addrNext  = blockAddr(sigLatched, blkInc);
                        stateNext = RD_REQ;
                    end
                end
            end
            CALC: begin
                // Results go back to the same addresses, starting at block 0.
                if (calcFlag) begin
                    calcFlagNext = 1'b0;
                    outReadyNext = 1'b1;
                    addrNext     = blockAddr(sigLatched, '0);
                    stateNext    = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (bus.acc_out_valid) begin
                    wrDataNext   = bus.acc_out_data;
                    outReadyNext = 1'b0;
                    wrReqNext    = 1'b1;
                    stateNext    = WR_REQ;
                end
            end
            WR_REQ: begin
                if (bus.mem_ack) begin
                    wrReqNext = 1'b0;
                    if (lastBlk) begin
                        blkNext   = '0;
                        doneNext  = 1'b1;
                        stateNext = DONE;
                    end else begin
                        blkNext      = blkInc;
                        addrNext     = blockAddr(sigLatched, blkInc);
                        outReadyNext = 1'b1;
                        stateNext    = WR_WAIT;
                    end
                end
            end
            DONE: begin
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_fft_xfer_sched.sv
// tb_fft_xfer_sched
// Directed bench for fft_xfer_sched with a small memory/accelerator model.
// Memory returns an address-derived pattern; the accelerator returns the
// bitwise inverse of each block, so every read and write can be predicted
// from the signal number and block index alone.
module tb_fft_xfer_sched;
    localparam int BLK_W  = 512;
    localparam int ADDR_W = 32;
    localparam int BLKS   = 128;

    logic clk;
    logic rst;

    fft_xfer_sched_if #(.BLK_W(BLK_W), .ADDR_W(ADDR_W)) bus ();

    fft_xfer_sched #(
        .BLK_W(BLK_W),
        .BLKS_PER_SIG(BLKS),
        .ADDR_W(ADDR_W),
        .SIG_BASE(32'h1000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount;
    int failCount;

    // Test configuration
    bit          bp;
    int          calcAt;
    int          holdAt;
    int          injectAtWr;
    bit          injected;
    bit          startReq;
    logic [17:0] startSigReq;

    // Model / scoreboard state
    logic [31:0] expBase;
    int          rdCount, inCount, wrCount, outIdx, doneCount;
    bit          calcPulsed, released;
    bit          memPending;
    int          memWait;
    int          calcPhase, calcWait, calcWaitRes;
    bit          running;
    int          runCycles, doneAt;
    logic [31:0] firstRdAddr, lastRdAddr, firstWrAddr, lastWrAddr;

    logic        prevRdReq, prevWrReq, prevAck, prevInValid, prevInReady, prevDone;
    logic [31:0] prevAddr;
    logic [511:0] prevWrData, prevInData;

    function automatic logic [511:0] blockData(input logic [31:0] a);
        return {8{a, a ^ 32'hA5A5_0F0F}};
    endfunction

    function automatic logic [31:0] sigBase(input logic [17:0] sig);
        return 32'h1000_0000 + (32'(sig) << 13);
    endfunction

    function automatic logic [31:0] expAddr(input int idx);
        return expBase + (32'(idx) << 6);
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        bp = 0; calcAt = BLKS; holdAt = -1; injectAtWr = -1; injected = 0;
        startReq = 0; startSigReq = '0; expBase = '0;
        rdCount = 0; inCount = 0; wrCount = 0; outIdx = 0; doneCount = 0;
        calcPulsed = 0; released = 0; memPending = 0; memWait = 0;
        calcPhase = 0; calcWait = 0; calcWaitRes = -1;
        running = 0; runCycles = 0; doneAt = -1;
        firstRdAddr = '0; lastRdAddr = '0; firstWrAddr = '0; lastWrAddr = '0;
        prevRdReq = 0; prevWrReq = 0; prevAck = 0; prevInValid = 0;
        prevInReady = 0; prevDone = 0; prevAddr = '0; prevWrData = '0; prevInData = '0;
    endtask

    // Drives all DUT inputs, called #1 after each rising edge.
    task automatic applyStimulus();
        bus.start = 1'b0;
        if (startReq) begin
            bus.start   = 1'b1;
            bus.sig_num = startSigReq;
            startReq    = 0;
        end else if (injectAtWr >= 0 && !injected && wrCount >= injectAtWr) begin
            bus.start   = 1'b1;
            bus.sig_num = 18'd9;
            injected    = 1;
        end

        bus.mem_ack     = 1'b0;
        bus.mem_rd_data = {16{32'hDEAD_BEEF}};
        if (!rst && (bus.mem_rd_req || bus.mem_wr_req)) begin
            if (!memPending) begin
                memPending = 1;
                memWait    = bp ? int'($urandom_range(0, 7)) : 0;
            end
            if (memWait == 0) begin
                bus.mem_ack = 1'b1;
                memPending  = 0;
                if (bus.mem_rd_req) bus.mem_rd_data = blockData(bus.mem_addr);
            end else begin
                memWait--;
            end
        end else begin
            memPending = 0;
        end

        if (holdAt >= 0 && inCount >= holdAt) bus.acc_in_ready = 1'b0;
        else bus.acc_in_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;

        bus.acc_calc_done = 1'b0;
        if (!calcPulsed && inCount >= calcAt) begin
            bus.acc_calc_done = 1'b1;
            calcPulsed        = 1;
            released          = 1;
        end
        bus.acc_out_valid = released && (outIdx < inCount);
        bus.acc_out_data  = bus.acc_out_valid ? ~blockData(expAddr(outIdx)) : '0;
    endtask

    // Observes the DUT at the falling edge; handshakes seen here complete at
    // the next rising edge.
    task automatic monitorCycle();
        logic rdHs, wrHs, inHs, outHs;
        rdHs  = bus.mem_rd_req && bus.mem_ack;
        wrHs  = bus.mem_wr_req && bus.mem_ack;
        inHs  = bus.acc_in_valid && bus.acc_in_ready;
        outHs = bus.acc_out_valid && bus.acc_out_ready;

        if (!rst) begin
            if (bus.mem_rd_req || bus.mem_wr_req)
                checkOutput("reqOverlap", 512'(bus.mem_rd_req & bus.mem_wr_req), 512'd0);
            if (prevRdReq && !prevAck) begin
                checkOutput("rdReqHold", 512'(bus.mem_rd_req), 512'd1);
                checkOutput("rdAddrHold", 512'(bus.mem_addr), 512'(prevAddr));
            end
            if (prevWrReq && !prevAck) begin
                checkOutput("wrReqHold", 512'(bus.mem_wr_req), 512'd1);
                checkOutput("wrAddrHold", 512'(bus.mem_addr), 512'(prevAddr));
                checkOutput("wrDataHold", bus.mem_wr_data, prevWrData);
            end
            if (prevInValid && !prevInReady) begin
                checkOutput("inValidHold", 512'(bus.acc_in_valid), 512'd1);
                checkOutput("inDataHold", bus.acc_in_data, prevInData);
            end
        end

        if (calcPhase == 1) begin
            if (bus.acc_out_ready) begin
                calcWaitRes = calcWait;
                calcPhase   = 2;
            end else begin
                calcWait++;
            end
        end

        if (rdHs) begin
            if (rdCount == 0) firstRdAddr = bus.mem_addr;
            lastRdAddr = bus.mem_addr;
            checkOutput("rdAddr", 512'(bus.mem_addr), 512'(expAddr(rdCount)));
            rdCount++;
        end
        if (inHs) begin
            checkOutput("inData", bus.acc_in_data, blockData(expAddr(inCount)));
            inCount++;
            if (inCount == BLKS) begin
                calcPhase = 1;
                calcWait  = 0;
            end
        end
        if (outHs) outIdx++;
        if (wrHs) begin
            if (wrCount == 0) firstWrAddr = bus.mem_addr;
            lastWrAddr = bus.mem_addr;
            checkOutput("wrAddr", 512'(bus.mem_addr), 512'(expAddr(wrCount)));
            checkOutput("wrData", bus.mem_wr_data, ~blockData(expAddr(wrCount)));
            wrCount++;
        end

        if (running) runCycles++;
        if (prevDone) checkOutput("busyFall", 512'(bus.busy), 512'd0);
        if (bus.done) begin
            doneCount++;
            checkOutput("busyAtDone", 512'(bus.busy), 512'd1);
            if (running) doneAt = runCycles;
            running = 0;
        end
        if (bus.start && !running && !rst) begin
            running   = 1;
            runCycles = 0;
        end

        prevRdReq   = bus.mem_rd_req;
        prevWrReq   = bus.mem_wr_req;
        prevAck     = bus.mem_ack;
        prevAddr    = bus.mem_addr;
        prevWrData  = bus.mem_wr_data;
        prevInValid = bus.acc_in_valid;
        prevInReady = bus.acc_in_ready;
        prevInData  = bus.acc_in_data;
        prevDone    = bus.done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        applyStimulus();
        @(negedge clk);
        monitorCycle();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".busy"}, 512'(bus.busy), 512'd0);
        checkOutput({tag, ".done"}, 512'(bus.done), 512'd0);
        checkOutput({tag, ".rdReq"}, 512'(bus.mem_rd_req), 512'd0);
        checkOutput({tag, ".wrReq"}, 512'(bus.mem_wr_req), 512'd0);
        checkOutput({tag, ".inValid"}, 512'(bus.acc_in_valid), 512'd0);
        checkOutput({tag, ".outReady"}, 512'(bus.acc_out_ready), 512'd0);
        checkOutput({tag, ".addr"}, 512'(bus.mem_addr), 512'd0);
        checkOutput({tag, ".wrData"}, bus.mem_wr_data, 512'd0);
        checkOutput({tag, ".inData"}, bus.acc_in_data, 512'd0);
    endtask

    task automatic runTransfer(input logic [17:0] sig, input int maxCycles,
                               input int tailCycles);
        int cycles;
        startSigReq = sig;
        startReq    = 1;
        expBase     = sigBase(sig);
        cycles      = 0;
        while (doneCount == 0 && cycles < maxCycles) begin
            tick();
            cycles++;
        end
        repeat (tailCycles) tick();
        checkOutput("doneCount", 512'(doneCount), 512'd1);
        checkOutput("rdCount", 512'(rdCount), 512'(BLKS));
        checkOutput("inCount", 512'(inCount), 512'(BLKS));
        checkOutput("wrCount", 512'(wrCount), 512'(BLKS));
    endtask

    initial begin
        int   waitCycles;
        bit   reached;
        assertCount = 0;
        failCount   = 0;
        resetModel();
        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.sig_num       = '0;
        bus.mem_ack       = 1'b0;
        bus.mem_rd_data   = '0;
        bus.acc_in_ready  = 1'b0;
        bus.acc_out_valid = 1'b0;
        bus.acc_out_data  = '0;
        bus.acc_calc_done = 1'b0;

        repeat (2) tick();
        checkIdleOutputs("reset");
        rst = 1'b0;
        tick();

        $display("[TB] immediate handshakes, sig 3");
        resetModel();
        runTransfer(18'd3, 2000, 3);
        checkOutput("t1.firstRd", 512'(firstRdAddr), 512'(32'h1000_6000));
        checkOutput("t1.lastRd", 512'(lastRdAddr), 512'(32'h1000_7FC0));
        checkOutput("t1.firstWr", 512'(firstWrAddr), 512'(32'h1000_6000));
        checkOutput("t1.lastWr", 512'(lastWrAddr), 512'(32'h1000_7FC0));
        checkOutput("t1.startToDone", 512'(doneAt), 512'd515);
        checkOutput("t1.calcWait", 512'(calcWaitRes), 512'd2);

        $display("[TB] random backpressure, sig 1");
        resetModel();
        bp = 1;
        runTransfer(18'd1, 20000, 3);
        checkOutput("t2.firstRd", 512'(firstRdAddr), 512'(32'h1000_2000));

        $display("[TB] early calc_done during block 5 read, sig 4");
        resetModel();
        calcAt = 5;
        runTransfer(18'd4, 2000, 3);
        checkOutput("t3.startToDone", 512'(doneAt), 512'd514);
        checkOutput("t3.calcWait", 512'(calcWaitRes), 512'd1);

        $display("[TB] start while busy, sig 2 with sig 9 injected");
        resetModel();
        injectAtWr = 10;
        runTransfer(18'd2, 2000, 20);
        checkOutput("t4.injected", 512'(injected), 512'd1);
        checkOutput("t4.firstRd", 512'(firstRdAddr), 512'(32'h1000_4000));
        checkOutput("t4.lastWr", 512'(lastWrAddr), 512'(32'h1000_5FC0));

        $display("[TB] reset during RD_PUSH at block 40");
        resetModel();
        holdAt      = 40;
        calcAt      = 1000;
        startSigReq = 18'd7;
        startReq    = 1;
        expBase     = sigBase(18'd7);
        reached     = 0;
        waitCycles  = 0;
        while (!reached && waitCycles < 2000) begin
            tick();
            waitCycles++;
            reached = (inCount == 40) && (rdCount == 41) && bus.acc_in_valid;
        end
        checkOutput("t5.holdReached", 512'(reached), 512'd1);
        rst = 1'b1;
        tick();
        checkIdleOutputs("t5.abort");
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("t5.noDone", 512'(doneCount), 512'd0);
        checkOutput("t5.idleBusy", 512'(bus.busy), 512'd0);
        resetModel();
        runTransfer(18'd0, 2000, 3);
        checkOutput("t5.firstRd", 512'(firstRdAddr), 512'(32'h1000_0000));

        $display("[TB] address wrap, sig 3FFFF");
        resetModel();
        runTransfer(18'h3FFFF, 2000, 3);
        checkOutput("t6.firstRd", 512'(firstRdAddr), 512'(32'h8FFF_E000));
        checkOutput("t6.lastWr", 512'(lastWrAddr), 512'(32'h8FFF_FFC0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
